// File: rtl/data_path.sv
// data_path: double-buffered SIZE/BRST control registers with HOLD/COMMIT
// Define WRITE_LOCK_EN to add the set-only CTRL.LOCK bit that freezes shadow and HOLD writes.
module data_path #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] dataIn,
    input  logic              write,
    output logic [DATA_W-1:0] dataOut,
    output logic [DATA_W-1:0] size,
    output logic [DATA_W-1:0] brst,
    output logic              pending
);
    logic [DATA_W-1:0] size_sh, brst_sh;
    logic              hold, commit, lock, wr_ok;
    logic              sel_size, sel_brst, sel_ctrl;
    assign sel_size = write && addr == ADDR_W'(0);
    assign sel_brst = write && addr == ADDR_W'(1);
    assign sel_ctrl = write && addr == ADDR_W'(2);
`ifdef WRITE_LOCK_EN
    always_ff @(posedge clk)
        if (reset)
            lock <= 1'b0;
        else if (sel_ctrl && dataIn[2])
            lock <= 1'b1;
`else
    assign lock = 1'b0;
`endif
    assign wr_ok = !lock;
    // Active copies load from pre-edge shadows, so a same-edge shadow write lands one load later.
    always_ff @(posedge clk)
        if (reset) begin
            size_sh <= '0;
            brst_sh <= '0;
            size    <= '0;
            brst    <= '0;
            hold    <= 1'b0;
            commit  <= 1'b0;
        end else begin
            if (!hold || commit) begin
                size <= size_sh;
                brst <= brst_sh;
            end
            if (sel_size && wr_ok)
                size_sh <= dataIn;
            if (sel_brst && wr_ok)
                brst_sh <= dataIn;
            if (sel_ctrl && wr_ok)
                hold <= dataIn[0];
            commit <= sel_ctrl && dataIn[1];
        end
    assign pending = (size_sh != size) || (brst_sh != brst);
    always_comb
        dataOut = addr == ADDR_W'(0) ? size_sh :
                  addr == ADDR_W'(1) ? brst_sh :
                  addr == ADDR_W'(2) ? DATA_W'({lock, 1'b0, hold}) :
                  addr == ADDR_W'(3) ? DATA_W'(pending) : '0;
endmodule

// File: tb/tb_data_path.sv
// tb_data_path: directed vectors with hand-computed expectations for data_path
module tb_data_path;
    logic        clk = 1'b0;
    logic        reset, write;
    logic [3:0]  addr;
    logic [31:0] dataIn, dataOut, size, brst;
    logic        pending;
    int          vec_cnt = 0, err_cnt = 0;
    data_path dut (
        .clk(clk), .reset(reset), .addr(addr), .dataIn(dataIn), .write(write),
        .dataOut(dataOut), .size(size), .brst(brst), .pending(pending)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, dataOut, exp);
    endtask
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        addr = a;
        dataIn = d;
        write = 1'b1;
        step();
        write = 1'b0;
    endtask
    initial begin
        reset = 1'b1; write = 1'b0; addr = '0; dataIn = '0;
        step();
        reset = 1'b0;
        check("rst_size", size, 0);
        check("rst_brst", brst, 0);
        check("rst_pending", 32'(pending), 0);
        for (int i = 0; i < 16; i++) rd($sformatf("rst_rd%0d", i), 4'(i), 0);
        // SIZE held write, HOLD=0
        addr = 0; dataIn = 10; write = 1'b1;
        step();
        check("sz_edge1", size, 0);
        check("sz_shadow", dataOut, 10);
        check("sz_pend", 32'(pending), 1);
        step();
        check("sz_edge2", size, 10);
        for (int i = 0; i < 3; i++) begin
            step();
            check("sz_stay", size, 10);
        end
        write = 1'b0; addr = 1; dataIn = 64;
        for (int i = 0; i < 5; i++) begin
            step();
            check("br_idle", brst, 0);
        end
        write = 1'b1;
        step();
        check("br_rd", dataOut, 64);
        check("br_edge1", brst, 0);
        step();
        check("br_edge2", brst, 64);
        write = 1'b0;
        // HOLD then COMMIT
        wr(2, 1);
        wr(0, 32'h55);
        check("hold_size", size, 10);
        check("hold_pend", 32'(pending), 1);
        rd("hold_status", 3, 1);
        step();
        check("hold_size2", size, 10);
        wr(2, 3);
        check("cmt_edgeN", size, 10);
        step();
        check("cmt_size", size, 32'h55);
        check("cmt_pend", 32'(pending), 0);
        rd("cmt_ctrl", 2, 1);
        step();
        check("cmt_hold_size", size, 32'h55);
        // read-only and unmapped writes
        wr(3, 32'hDEADBEEF);
        wr(9, 32'hDEADBEEF);
        check("um_size", size, 32'h55);
        check("um_brst", brst, 64);
        rd("um_rd9", 9, 0);
        rd("um_status", 3, 0);
        rd("um_rd0", 0, 32'h55);
        rd("um_rd1", 1, 64);
        rd("um_ctrl", 2, 1);
        // reset beats simultaneous write
        reset = 1'b1; addr = 0; dataIn = 7; write = 1'b1;
        step();
        reset = 1'b0; write = 1'b0;
        rd("rp_shadow", 0, 0);
        check("rp_size", size, 0);
        rd("rp_ctrl", 2, 0);
        step();
        check("rp_size2", size, 0);
        check("rp_pend", 32'(pending), 0);
`ifdef WRITE_LOCK_EN
        wr(0, 5);
        step();
        check("lk_pre", size, 5);
        wr(2, 4);
        wr(0, 99);
        wr(2, 1);
        step();
        check("lk_size", size, 5);
        rd("lk_shadow", 0, 5);
        rd("lk_ctrl", 2, 4);
        wr(2, 0);
        rd("lk_setonly", 2, 4);
        reset = 1'b1;
        step();
        reset = 1'b0;
        rd("lk_clr", 2, 0);
        wr(0, 99);
        step();
        check("lk_after", size, 99);
`else
        wr(2, 4);
        rd("nolk_ctrl", 2, 0);
        wr(0, 99);
        step();
        check("nolk_size", size, 99);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
